// File: rtl/pat_field_buffer.sv
// Banked field buffer: the processor reads and writes fields in any buffer, and a
// selected buffer can be streamed out over a valid/ready interface.
module pat_field_buffer #(
    parameter int BUFP_WIDTH   = 3,
    parameter int FIELDP_WIDTH = 5,
    parameter int FIELD_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [BUFP_WIDTH-1:0]   bufp,
    input  logic [FIELDP_WIDTH-1:0] fieldp,
    input  logic [FIELDP_WIDTH-1:0] fieldwp,
    input  logic                    field_wr,
    input  logic [FIELD_WIDTH-1:0]  field_wdata,
    output logic [FIELD_WIDTH-1:0]  field_rdata,
    input  logic                    emit,
    input  logic [FIELDP_WIDTH-1:0] emit_len,
    output logic                    busy,
    output logic                    wr_drop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FIELD_WIDTH-1:0]  out_data,
    output logic                    out_last
);

    localparam int ADDR_WIDTH = BUFP_WIDTH + FIELDP_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t state, state_nxt;

    logic [FIELD_WIDTH-1:0]  mem [DEPTH];
    logic [BUFP_WIDTH-1:0]   sbuf;
    logic [FIELDP_WIDTH-1:0] last;
    logic [FIELDP_WIDTH-1:0] idx;
    logic [FIELDP_WIDTH-1:0] idx_nxt;
    logic [ADDR_WIDTH-1:0]   waddr, raddr, saddr;
    logic [FIELD_WIDTH-1:0]  sword;
    logic                    wr_block, wr_en;
    logic                    beat_done;
    logic                    accept, load_first, load_next, finish;

    // The streamed buffer is write-protected for the whole transfer, so the stream
    // path never needs write forwarding.
    assign wr_block  = field_wr && busy && (bufp == sbuf);
    assign wr_en     = field_wr && !wr_block;
    assign waddr     = {bufp, fieldwp};
    assign raddr     = {bufp, fieldp};
    assign beat_done = out_valid && out_ready;
    assign idx_nxt   = idx + FIELDP_WIDTH'(1);
    assign saddr     = {sbuf, (load_next ? idx_nxt : idx)};
    assign sword     = mem[saddr];

    // NOTE: the field array is deliberately left out of reset so it maps onto plain
    // RAM; only control state and output registers are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= field_wdata;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // sample pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field_rdata <= '0;
            wr_drop     <= 1'b0;
        end else begin
            field_rdata <= (wr_en && (waddr == raddr)) ? field_wdata : mem[raddr];
            wr_drop     <= wr_block;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: each combinational block assigns defaults first so no path can infer
    // a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (emit) state_nxt = FETCH;
            FETCH:   state_nxt = STREAM;
            STREAM:  if (beat_done && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        accept     = (state == IDLE) && emit;
        load_first = (state == FETCH);
        load_next  = (state == STREAM) && beat_done && !out_last;
        finish     = (state == STREAM) && beat_done && out_last;
    end

    // The next field is loaded on the same edge that retires the current one, which
    // sustains one beat per cycle while out_ready stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf      <= '0;
            last      <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                sbuf <= bufp;
                last <= emit_len;
                idx  <= '0;
            end
            if (load_first) begin
                out_data  <= sword;
                out_last  <= (idx == last);
                out_valid <= 1'b1;
            end else if (load_next) begin
                idx      <= idx_nxt;
                out_data <= sword;
                out_last <= (idx_nxt == last);
            end else if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
